fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch stage with a small prefetch buffer, sitting between the program counter/instruction memory and the decode/register-file stage. It generates sequential word addresses and fetches from an instruction memory over a req/ack handshake that tolerates wait states. Fetched {pc, instruction} pairs are buffered in a FIFO and delivered to decode over a valid/ready handshake. A branch/jump redirect flushes the buffer and restarts fetch at the target.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  word address; bits [1:0] always 0; stable while imem_req=1 and no ack
- imem_ack  in  1  transfer complete this cycle; may assert in the same cycle imem_req rises
- imem_rdata  in  32  instruction; valid only when imem_ack=1
- ins_valid  out  1  head entry available
- ins_data  out  32  head instruction
- ins_pc  out  32  address of head instruction
- ins_ready  in  1  decode accepts head this cycle
- redirect  in  1  one-cycle pulse: discard buffer, refetch from redirect_pc
- redirect_pc  in  32  target; bits [1:0] ignored (forced 0)

## Operation
- Reset values: imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins_data=0, ins_pc=0; FIFO empty; state FETCH; fetch_pc=RESET_PC.
- Occupancy = FIFO count + (1 if a request is outstanding). A request is issued only when occupancy < DEPTH, so a returning word always has a free slot; no overflow path exists.
- States:
  - FETCH: imem_req=0. If occupancy < DEPTH: assert imem_req with imem_addr=fetch_pc, go to WAIT.
  - WAIT: imem_req=1, address held. On imem_ack: push {imem_addr, imem_rdata}, fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0). If post-push/pop occupancy < DEPTH, keep imem_req=1 with the next address (back-to-back) and stay in WAIT; otherwise go to FETCH.
  - DISCARD: entered on redirect while a request is outstanding without ack. imem_req and the old address are held until imem_ack; data is dropped. Then issue at the new fetch_pc (same rule as FETCH).
- Redirect, highest priority:
  - FIFO flushed; fetch_pc = {redirect_pc[31:2], 2'b00}.
  - A pop in the same cycle completes; the ins_* values were consumed.
  - Ack in the same cycle: word dropped, state FETCH.
  - Outstanding without ack: DISCARD.
  - Redirect in DISCARD: update fetch_pc only.
- Decode: pop when ins_valid && ins_ready. No bypass: a pushed word is visible the cycle after its ack. Push and pop in the same cycle leaves count unchanged.

## Timing
- From reset deassertion: edge 1 raises imem_req with address RESET_PC. With a zero-wait memory (ack the same cycle), edge 2 pushes the word and ins_valid=1 after edge 2.
- Zero-wait throughput: one instruction per cycle while ins_ready=1. N wait states give one instruction per N+1 cycles.
- Redirect to first new instruction, zero-wait memory: 3 edges (reissue, ack/push, visible). Each held DISCARD cycle adds one edge.
- Count width: $clog2(DEPTH+1). Pointers wrap modulo DEPTH.

## Structure
- Shared package cpu_pkg holds:
  - fetch state enum {FETCH, WAIT, DISCARD}
  - INSN_W=32 and the PC increment constant 4
  - default RESET_PC
- One sub-module: fetch_fifo, a synchronous FIFO of {pc, insn} with push, pop, flush, count, and registered head outputs.

## Test plan
- Reset, then zero-wait memory returning addr^32'hA5A5_0000, with ins_ready=1 throughout: ins_pc sequence 0,4,8,… one per cycle from edge 2, and ins_data matches.
- ins_ready=0 with DEPTH=4: exactly 4 entries buffered (pcs 0..C), imem_req low, no fifth request. Raise ins_ready: pcs 0,4,8,C drain in order, then fetch resumes at 0x10.
- Memory with 2 wait states: imem_addr is stable across the wait cycles, and one instruction arrives every 3 cycles.
- Redirect to 0x103 while a request for 0x8 is outstanding: DISCARD holds addr 0x8 until ack, that word never appears, and the next delivered ins_pc=0x100.
- Redirect in the same cycle as ack and a pop: popped entry is consumed, acked word dropped, FIFO empty next cycle, next fetch at target. Also run fetch_pc=0xFFFF_FFFC: the following fetch address is 0.
- Assert reset mid-WAIT: imem_req=0 and ins_valid=0 immediately (asynchronously), and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : fetch control states (FETCH, WAIT, DISCARD)
//   INSN_W        : instruction width
//   PC_INC        : sequential fetch step in bytes
//   DEFAULT_RESET_PC : first fetch address after reset unless overridden
//   next_pc()     : sequential successor of a word address (wraps mod 2^32)
package cpu_pkg;

  localparam int          INSN_W           = 32;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, insn} pairs with registered head outputs.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   push, push_pc/insn     : write one entry (ignored while flushing)
//   pop                    : remove the head entry
//   flush                  : empty the buffer (wins over push and pop)
//   count                  : number of stored entries, 0..DEPTH
//   head_valid/pc/insn     : registered view of the oldest entry
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [31:0]                push_pc,
  input  logic [INSN_W-1:0]          push_insn,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       head_valid,
  output logic [31:0]                head_pc,
  output logic [INSN_W-1:0]          head_insn
);

  localparam int              CW   = $clog2(DEPTH + 1);
  localparam int              PW   = $clog2(DEPTH);
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [31:0]       mem_pc   [DEPTH];
  logic [INSN_W-1:0] mem_insn [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_ptr_nxt;
  logic [CW-1:0]     count_after_pop, count_nxt;
  logic              do_pop, do_push;

  assign do_pop          = pop & (count != '0);
  assign do_push         = push & ~flush & ((count != FULL) | do_pop);
  assign rd_ptr_nxt      = rd_ptr + PW'(do_pop);
  assign count_after_pop = count - CW'(do_pop);
  assign count_nxt       = count_after_pop + CW'(do_push);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_pc[wr_ptr]   <= push_pc;
      mem_insn[wr_ptr] <= push_insn;
    end
  end

  // The head register is reloaded every edge: from storage when an older
  // entry survives the pop, or straight from the push data when the
  // incoming word becomes the only entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_pc    <= '0;
      head_insn  <= '0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      if (count_after_pop != '0) begin
        head_pc   <= mem_pc[rd_ptr_nxt];
        head_insn <= mem_insn[rd_ptr_nxt];
      end else if (do_push) begin
        head_pc   <= push_pc;
        head_insn <= push_insn;
      end
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage with prefetch buffer.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   imem_req/addr       : registered fetch request and word address
//   imem_ack/rdata      : memory completes the request this cycle
//   ins_valid/data/pc   : head of the prefetch buffer toward decode
//   ins_ready           : decode takes the head this cycle
//   redirect/_pc        : one-cycle pulse that flushes and restarts fetch
//   fsm_state           : current fetch state (debug visibility)
// Handshakes: a memory transfer completes on any edge where imem_req and
// imem_ack are both high; imem_addr is held while imem_req is high and no
// ack has arrived. A decode transfer completes on any edge where ins_valid
// and ins_ready are both high; ins_* stay stable until then.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  output logic              ins_valid,
  output logic [INSN_W-1:0] ins_data,
  output logic [31:0]       ins_pc,
  input  logic              ins_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [1:0]        fsm_state
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   target;
  logic [CW-1:0] fifo_count;
  logic          pop, push, room_now, room_after;

  assign fsm_state = state;
  assign pop       = ins_valid & ins_ready;
  // A word acked while redirecting belongs to the old stream: never stored.
  assign push      = (state == WAIT) & imem_ack & ~redirect;
  assign target    = redirect_pc & 32'hFFFF_FFFC;

  // Outstanding requests always have a reserved slot, so "room" is judged
  // on count plus the request being issued.
  assign room_now   = fifo_count < FULL;
  assign room_after = (fifo_count + CW'(1) - CW'(pop)) < FULL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= target;
      if (state != FETCH) begin
        if (imem_ack) begin
          state    <= FETCH;
          imem_req <= 1'b0;
        end else begin
          // Old request must still complete on the bus; its data is dropped.
          state <= DISCARD;
        end
      end
    end else begin
      case (state)
        FETCH: begin
          if (room_now) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            fetch_pc <= next_pc(fetch_pc);
            if (room_after) begin
              imem_addr <= next_pc(fetch_pc);
            end else begin
              imem_req <= 1'b0;
              state    <= FETCH;
            end
          end
        end
        DISCARD: begin
          if (imem_ack) begin
            if (room_now) begin
              imem_addr <= fetch_pc;
              state     <= WAIT;
            end else begin
              imem_req <= 1'b0;
              state    <= FETCH;
            end
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= FETCH;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_pc   (imem_addr),
    .push_insn (imem_rdata),
    .pop       (pop),
    .flush     (redirect),
    .count     (fifo_count),
    .head_valid(ins_valid),
    .head_pc   (ins_pc),
    .head_insn (ins_data)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory responder with random wait states, a
// stream-level reference model feeding an expected queue, and a monitor
// that pops and compares whenever decode takes an instruction.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_pc(ins_pc),
    .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  int          push_cnt = 0;
  int          pop_cnt  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic        discard;
  logic        prev_pend;
  logic [31:0] prev_addr;

  int          ws_min = 0, ws_max = 0, cur_ws = 0, wcnt = 0;
  logic        mem_en = 1'b1;
  logic        found;
  int          p0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  // Instruction word at address a is a ^ KEY. Wait states per request are
  // drawn from [ws_min, ws_max].
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (reset || !mem_en) begin
        imem_ack = 1'b0;
        wcnt     = 0;
        if (reset) cur_ws = ws_min;
      end else if (imem_req) begin
        if (wcnt >= cur_ws) begin
          imem_ack   = 1'b1;
          imem_rdata = imem_addr ^ KEY;
          wcnt       = 0;
          cur_ws     = $urandom_range(ws_max, ws_min);
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Instruction stream view: after reset/redirect the useful fetches are
  // target, target+4, ...; a request left hanging by a redirect yields one
  // ack that carries nothing; a redirect empties everything not yet taken.
  initial begin
    model_pc  = RESET_PC;
    discard   = 1'b0;
    prev_pend = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk); #1;
      if (reset) begin
        exp_q.delete();
        model_pc  = RESET_PC;
        discard   = 1'b0;
        prev_pend = 1'b0;
      end else begin
        if (prev_pend) begin
          check("addr_hold_req", imem_req, 1'b1);
          check("addr_hold", imem_addr, prev_addr);
        end
        if (redirect) begin
          exp_q.delete();
          model_pc = redirect_pc & 32'hFFFF_FFFC;
          if (imem_req && !imem_ack) discard = 1'b1;
          else if (imem_req && imem_ack) discard = 1'b0;
        end else if (imem_req && imem_ack) begin
          if (discard) begin
            discard = 1'b0;
          end else begin
            check("fetch_addr", imem_addr, model_pc);
            exp_q.push_back({model_pc, model_pc ^ KEY});
            model_pc = model_pc + 32'd4;
            push_cnt++;
          end
        end
        prev_pend = imem_req && !imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("occupancy", 32'(exp_q.size() + (imem_req ? 1 : 0) <= DEPTH), 32'd1);
        check("ins_valid", ins_valid, exp_q.size() != 0);
        if (ins_valid && ins_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("ins_pc", ins_pc, e[63:32]);
          check("ins_data", ins_data, e[31:0]);
          pop_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset    = 1'b1;
    redirect = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b1;
    ins_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #7;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", ins_valid, 1'b0);
    check("rst_data", ins_data, 32'h0);
    check("rst_pc", ins_pc, 32'h0);

    // First-fetch timing and zero-wait throughput
    reset     = 1'b0;
    ins_ready = 1'b1;
    step();
    check("edge1_req", imem_req, 1'b1);
    check("edge1_addr", imem_addr, RESET_PC);
    check("edge1_valid", ins_valid, 1'b0);
    step();
    check("edge2_valid", ins_valid, 1'b1);
    check("edge2_pc", ins_pc, RESET_PC);
    check("edge2_data", ins_data, RESET_PC ^ KEY);
    p0 = pop_cnt;
    repeat (20) step();
    check("zw_rate", pop_cnt - p0, 32'd20);

    // Buffer fills to DEPTH with decode stalled, then drains and resumes
    ins_ready = 1'b0;
    do_reset();
    p0 = push_cnt;
    repeat (10) step();
    check("full_pushes", push_cnt - p0, 32'd4);
    check("full_req", imem_req, 1'b0);
    check("full_head", ins_pc, 32'h0);
    ins_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req) begin found = 1'b1; break; end
    end
    check("resume_seen", found, 1'b1);
    check("resume_addr", imem_addr, 32'h10);

    // Two wait states: one instruction every three cycles
    ws_min = 2; ws_max = 2;
    do_reset();
    repeat (10) step();
    p0 = push_cnt;
    repeat (30) step();
    check("ws2_rate", push_cnt - p0, 32'd10);

    // Redirect while the request for 0x8 is outstanding
    ws_min = 3; ws_max = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (imem_req && imem_addr == 32'h8 && !imem_ack) begin found = 1'b1; break; end
    end
    check("disc_setup", found, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    step();
    redirect = 1'b0;
    check("disc_req", imem_req, 1'b1);
    check("disc_addr", imem_addr, 32'h8);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ins_valid) begin found = 1'b1; break; end
    end
    check("disc_seen", found, 1'b1);
    check("disc_first_pc", ins_pc, 32'h100);

    // Redirect together with ack and pop; target at the top of memory
    ws_min = 0; ws_max = 0;
    do_reset();
    repeat (6) step();
    check("sc_pre", {29'd0, ins_valid, imem_req, imem_ack}, 32'd7);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("sc_empty", ins_valid, 1'b0);
    check("sc_req_low", imem_req, 1'b0);
    step();
    check("sc_req", imem_req, 1'b1);
    check("sc_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_valid", ins_valid, 1'b1);
    check("wrap_pc", ins_pc, 32'hFFFF_FFFC);

    // Asynchronous reset in the middle of a wait
    ws_min = 6; ws_max = 6;
    ins_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ins_valid && imem_req && !imem_ack) begin found = 1'b1; break; end
    end
    check("ar_setup", found, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("ar_req", imem_req, 1'b0);
    check("ar_valid", ins_valid, 1'b0);
    ws_min = 0; ws_max = 0;
    ins_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("ar_restart_req", imem_req, 1'b1);
    check("ar_restart_addr", imem_addr, RESET_PC);

    // Randomized traffic: wait states, decode stalls, redirects
    ws_min = 0; ws_max = 3;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step();
      if (i % 300 == 0) ws_max = $urandom_range(0, 3);
      redirect  = 1'b0;
      ins_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        redirect    = 1'b1;
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                   : $urandom;
      end
    end

    // Drain: stop memory, decode everything still buffered
    step();
    redirect  = 1'b0;
    mem_en    = 1'b0;
    ins_ready = 1'b1;
    repeat (12) step();
    check("drain_empty", exp_q.size(), 32'd0);
    check("drain_valid", ins_valid, 1'b0);
    check("deliveries", 32'(pop_cnt > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
